mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, number of busy cycles without mem_ack before abort; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  reset; synchronous, active-low.
REQ-004 Port: if_req  input  1  instruction-fetch read request; held until if_ready.
REQ-005 Port: if_addr  input  32  fetch address.
REQ-006 Port: if_rdata  output  32  fetched word, registered.
REQ-007 Port: if_ready  output  1  one-cycle completion pulse, fetch side.
REQ-008 Port: d_req  input  1  data-stage request; held until d_ready.
REQ-009 Port: d_we  input  1  1 = store, 0 = load.
REQ-010 Port: d_addr  input  32  data address.
REQ-011 Port: d_wdata  input  32  store data.
REQ-012 Port: d_rdata  output  32  loaded word, registered.
REQ-013 Port: d_ready  output  1  one-cycle completion pulse, data side.
REQ-014 Port: err  output  1  one-cycle pulse with a ready pulse when the transaction timed out.
REQ-015 Port: mem_en  output  1  memory transaction active.
REQ-016 Port: mem_we  output  1  memory write enable.
REQ-017 Port: mem_addr  output  32  memory address, registered at grant.
REQ-018 Port: mem_wdata  output  32  memory write data, registered at grant.
REQ-019 Port: mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-020 Port: mem_ack  input  1  memory completion, single cycle.
REQ-021 Port: stall  output  1  pipeline hold (PC, IF/ID) while any request is outstanding.

Function
REQ-022 FSM states SHALL be IDLE, BUSY_I and BUSY_D.
REQ-023 In IDLE with only d_req: go to BUSY_D; with only if_req: go to BUSY_I; with neither: stay in IDLE.
REQ-024 In IDLE with both requests, grant SHALL go to data unless the last completed grant was data, in which case it goes to instruction (last_grant flag).
REQ-025 On grant edge: mem_addr/mem_wdata/mem_we SHALL latch the winner's address, data and write flag; mem_we is always 0 for instruction grants.
REQ-026 mem_en SHALL be 1 exactly while in BUSY_I or BUSY_D; mem_addr, mem_wdata and mem_we SHALL hold stable throughout busy.
REQ-027 In busy with mem_ack=1: the requester's ready SHALL be 1 in the following cycle, the FSM SHALL go to IDLE and last_grant SHALL update.
REQ-028 Reads SHALL load if_rdata or d_rdata from mem_rdata on the ack edge; stores SHALL leave d_rdata unchanged.
REQ-029 Minimum latency SHALL be 3 cycles: req sampled at edge N, ack earliest in cycle N+1, ready in N+2.
REQ-030 A busy-cycle counter (8-bit) SHALL clear on grant and increment each busy cycle without ack.
REQ-031 When the counter reaches TIMEOUT-1 without ack, the FSM SHALL go to IDLE, pulse ready with err=1, and write rdata with 0.
REQ-032 mem_ack in IDLE SHALL be ignored with no state or output change.
REQ-033 A requester's req SHALL be ignored in the cycle its ready is 1, so a held req cannot double-grant.
REQ-034 stall = (if_req & ~if_ready) | (d_req & ~d_ready), combinational.
REQ-035 Ready and err pulses SHALL last exactly one cycle.

Reset
REQ-036 With reset=0 at an edge: FSM=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=d_ready=err=0, if_rdata=d_rdata=0, counter=0, last_grant=instruction.
REQ-037 Reset mid-transaction SHALL abort with no ready pulse; a late mem_ack after reset SHALL be ignored per REQ-032.

Verification
REQ-038 Fetch only: if_req=1, if_addr=0x40, ack after 2 busy cycles with mem_rdata=0x8C0A0004 -> mem_addr=0x40, mem_we=0, if_ready pulse 1 cycle, if_rdata=0x8C0A0004.
REQ-039 Simultaneous requests, both held: data store 0x100<-0xDEADBEEF granted first (mem_we=1), then fetch 0x44; then next simultaneous pair goes to data again (alternation).
REQ-040 Timeout, TIMEOUT=4, no ack -> after 4 busy cycles d_ready=1, err=1, d_rdata=0, mem_en=0, FSM=IDLE.
REQ-041 Reset=0 during BUSY_D, then ack arrives -> all outputs at reset values, no d_ready, no state change.
REQ-042 Back-to-back loads with d_req held through d_ready -> exactly one grant per load, and stall=1 in every cycle until each d_ready.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch-side, data-side and memory-side signals around mem_port_arbiter.
// The arbiter takes the slave view; the core/memory environment takes the master view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready, err, mem_en, mem_we, mem_addr, mem_wdata,
    input  stall
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready, err, mem_en, mem_we, mem_addr, mem_wdata,
    output stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data stage,
// alternating on contention and aborting a transaction after TIMEOUT unacked busy cycles.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        last_grant_q;  // 1 = last completed grant went to data
  logic        mem_en_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic        if_ready_q;
  logic        d_ready_q;
  logic        err_q;

  logic if_req_v, d_req_v, grant_d, grant_i, timeout, done;

  // A request seen in its own ready cycle is the one just served, not a new one.
  assign if_req_v = bus.if_req & ~if_ready_q;
  assign d_req_v  = bus.d_req & ~d_ready_q;
  assign grant_d  = d_req_v & (~if_req_v | ~last_grant_q);
  assign grant_i  = if_req_v & ~grant_d;
  assign timeout  = ~bus.mem_ack & (cnt_q == TimeoutLast);
  assign done     = bus.mem_ack | timeout;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_d) begin
            state_q     <= StBusyD;
            cnt_q       <= '0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
          end else if (grant_i) begin
            state_q     <= StBusyI;
            cnt_q       <= '0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
          end
        end
        StBusyI, StBusyD: begin
          if (done) begin
            state_q      <= StIdle;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            err_q        <= timeout;
            last_grant_q <= (state_q == StBusyD);
            if (state_q == StBusyI) begin
              if_ready_q <= 1'b1;
              if_rdata_q <= timeout ? 32'h0 : bus.mem_rdata;
            end else begin
              d_ready_q <= 1'b1;
              // Stores keep the previous load result; aborts always return zero.
              if (timeout)        d_rdata_q <= '0;
              else if (!mem_we_q) d_rdata_q <= bus.mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.err       = err_q;
  assign bus.stall     = (bus.if_req & ~if_ready_q) | (bus.d_req & ~d_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, back-to-back loads, contention,
// timeout, reset abort and last-grant reset, each step checked against hand values.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;

    // Reset values
    step();
    step();
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_if_ready", bus.if_ready, 0);
    check("rst_d_ready", bus.d_ready, 0);
    check("rst_err", bus.err, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    check("rst_stall", bus.stall, 0);
    reset = 1'b1;
    step();

    // Back-to-back loads with d_req held through d_ready, ack at minimum latency
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h200;
    #1;
    check("ld1_stall_req", bus.stall, 1);
    step();
    check("ld1_mem_en", bus.mem_en, 1);
    check("ld1_mem_addr", bus.mem_addr, 32'h200);
    check("ld1_mem_we", bus.mem_we, 0);
    check("ld1_stall_busy", bus.stall, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hA5A5_0001;
    step();
    check("ld1_d_ready", bus.d_ready, 1);
    check("ld1_d_rdata", bus.d_rdata, 32'hA5A5_0001);
    check("ld1_err", bus.err, 0);
    check("ld1_mem_en_done", bus.mem_en, 0);
    check("ld1_stall_ready", bus.stall, 0);
    bus.mem_ack = 1'b0;
    bus.d_addr  = 32'h204;
    step();
    check("ld2_no_double_grant", bus.mem_en, 0);
    check("ld1_ready_pulse", bus.d_ready, 0);
    check("ld2_stall_wait", bus.stall, 1);
    step();
    check("ld2_mem_en", bus.mem_en, 1);
    check("ld2_mem_addr", bus.mem_addr, 32'h204);
    check("ld2_stall_busy1", bus.stall, 1);
    step();
    check("ld2_stall_busy2", bus.stall, 1);
    check("ld2_mem_en_hold", bus.mem_en, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hA5A5_0002;
    step();
    check("ld2_d_ready", bus.d_ready, 1);
    check("ld2_d_rdata", bus.d_rdata, 32'hA5A5_0002);
    check("ld2_stall_ready", bus.stall, 0);
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    step();
    check("ld2_ready_pulse", bus.d_ready, 0);
    check("ld2_idle", bus.mem_en, 0);

    // Fetch only, ack after two busy cycles
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    step();
    check("if_mem_en", bus.mem_en, 1);
    check("if_mem_addr", bus.mem_addr, 32'h40);
    check("if_mem_we", bus.mem_we, 0);
    step();
    check("if_not_ready_yet", bus.if_ready, 0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h8C0A_0004;
    step();
    check("if_ready", bus.if_ready, 1);
    check("if_rdata", bus.if_rdata, 32'h8C0A_0004);
    check("if_d_ready_quiet", bus.d_ready, 0);
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    step();
    check("if_ready_pulse", bus.if_ready, 0);
    check("if_rdata_hold", bus.if_rdata, 32'h8C0A_0004);

    // Contention: last grant was instruction, so the data store wins first
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h100;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h44;
    step();
    check("arb1_mem_addr", bus.mem_addr, 32'h100);
    check("arb1_mem_we", bus.mem_we, 1);
    check("arb1_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    step();
    check("arb1_addr_stable", bus.mem_addr, 32'h100);
    check("arb1_we_stable", bus.mem_we, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1111_1111;
    step();
    check("arb1_d_ready", bus.d_ready, 1);
    check("arb1_store_keeps_rdata", bus.d_rdata, 32'hA5A5_0002);
    check("arb1_stall_fetch_wait", bus.stall, 1);
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    step();
    check("arb2_mem_en", bus.mem_en, 1);
    check("arb2_mem_addr", bus.mem_addr, 32'h44);
    check("arb2_mem_we", bus.mem_we, 0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0013;
    step();
    check("arb2_if_ready", bus.if_ready, 1);
    check("arb2_if_rdata", bus.if_rdata, 32'h13);
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    step();
    // Last grant was instruction again: next simultaneous pair goes to data
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h300;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h48;
    step();
    check("arb3_mem_addr", bus.mem_addr, 32'h300);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h77;
    step();
    check("arb3_d_rdata", bus.d_rdata, 32'h77);
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    bus.if_req  = 1'b0;
    step();

    // Timeout (TIMEOUT=4): four unacked busy cycles, then d_ready with err
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h400;
    step();
    check("to_mem_en_b1", bus.mem_en, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_still_busy", bus.mem_en, 1);
      check("to_no_ready", bus.d_ready, 0);
    end
    step();
    check("to_d_ready", bus.d_ready, 1);
    check("to_err", bus.err, 1);
    check("to_d_rdata_zero", bus.d_rdata, 0);
    check("to_mem_en_off", bus.mem_en, 0);
    bus.d_req = 1'b0;
    step();
    check("to_err_pulse", bus.err, 0);
    check("to_ready_pulse", bus.d_ready, 0);
    check("to_idle", bus.mem_en, 0);

    // Reset during BUSY_D, then a late ack
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h500;
    bus.d_wdata = 32'h1234;
    step();
    check("rb_busy", bus.mem_en, 1);
    reset = 1'b0;
    step();
    check("rb_mem_en", bus.mem_en, 0);
    check("rb_mem_we", bus.mem_we, 0);
    check("rb_mem_addr", bus.mem_addr, 0);
    check("rb_mem_wdata", bus.mem_wdata, 0);
    check("rb_if_rdata", bus.if_rdata, 0);
    check("rb_d_ready", bus.d_ready, 0);
    reset         = 1'b1;
    bus.d_req     = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    step();
    check("rb_late_ack_ready", bus.d_ready, 0);
    check("rb_late_ack_rdata", bus.d_rdata, 0);
    check("rb_late_ack_err", bus.err, 0);
    step();
    check("rb_late_ack_idle", bus.mem_en, 0);
    bus.mem_ack = 1'b0;

    // Reset restores last_grant=instruction, so data wins the next tie
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h604;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h600;
    step();
    check("lg_reset_data_wins", bus.mem_addr, 32'h604);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5A;
    step();
    check("lg_d_ready", bus.d_ready, 1);
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    bus.if_req  = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
